// File: rtl/arith_accum_top.sv
`default_nettype none
// ============================================================================
// Module      : arith_accum_top
// Description : Two-stage pipelined multiply-accumulate datapath. Each cycle
//               it multiplies three 12-bit unsigned operands (a*b*c, 36-bit
//               exact) and, when the sampled enable is high, adds the product
//               into a 40-bit running sum that wraps modulo 2^40.
//
// Ports       : clk   in   1  rising-edge clock
//               rst_n in   1  synchronous active-low reset
//               a     in  12  unsigned operand A
//               b     in  12  unsigned operand B
//               c     in  12  unsigned operand C
//               e     in   1  accumulate enable, sampled at the clock edge
//               y     out 40  registered accumulator value
//
// Revision    : 1.0  initial release
// ============================================================================
module arith_accum_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [11:0] c,
    input  logic        e,
    output logic [39:0] y
);

    // Stage 1 registers: partial product, delayed C operand and enable.
    logic [23:0] r_p1;
    logic [11:0] r_c1;
    logic        r_v1;

    // Stage 2 register: running sum.
    logic [39:0] r_acc;

    logic [23:0] w_ab;
    logic [35:0] w_prod;
    logic [39:0] w_sum;

    // Operands are widened explicitly so each multiply is exact at its
    // result width.
    assign w_ab   = {12'd0, a} * {12'd0, b};
    assign w_prod = {12'd0, r_p1} * {24'd0, r_c1};
    // The carry out of bit 39 is dropped: the sum wraps modulo 2^40.
    assign w_sum  = r_acc + {4'd0, w_prod};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p1 <= 24'd0;
            r_c1 <= 12'd0;
            r_v1 <= 1'b0;
        end else begin
            r_p1 <= w_ab;
            r_c1 <= c;
            r_v1 <= e;
        end
    end

    // Clearing r_v1 on reset together with r_acc discards any operand set
    // that was in flight, so accumulation restarts cleanly from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= 40'd0;
        end else if (r_v1) begin
            r_acc <= w_sum;
        end
    end

    assign y = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_arith_accum_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_accum_top
// Description : Self-checking bench for arith_accum_top. A table of vectors
//               (with known expected sums) drives reset, single, repeated,
//               glitchy-enable and mid-run reset cases; hand-written
//               sequences cover wrap-around and a random run. Expected y
//               values are computed from a behavioural sum and queued when
//               stimulus is driven, then popped when the DUT output is due.
//
// Revision    : 1.0  initial release
// ============================================================================
module tb_arith_accum_top;

    logic        clk;
    logic        rst_n;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic        e;
    logic [39:0] y;

    arith_accum_top u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .e     (e),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] c;
        logic        e;
        bit          glitch;
        logic [39:0] exp_y;
    } vec_t;

    localparam logic [11:0] c_oa = 12'h76C;
    localparam logic [11:0] c_ob = 12'h020;
    localparam logic [11:0] c_oc = 12'h0A5;
    localparam logic [39:0] c_p  = 40'd10032000;  // 0x991380

    int          pass_cnt;
    int          total_cnt;
    logic [39:0] sbq[$];   // expected y after each upcoming edge
    logic [63:0] m_sum;    // behavioural running sum (reduced mod 2^40)

    function automatic logic [63:0] prod3(input logic [11:0] x0, input logic [11:0] x1,
                                          input logic [11:0] x2);
        logic [63:0] r;
        r = 64'(x0) * 64'(x1) * 64'(x2);
        return r;
    endfunction

    task automatic check(input string nm, input logic [39:0] got, input logic [39:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: y=0x%010h expected 0x%010h", nm, got, exp);
    endtask

    // One clock cycle: drive inputs just after an edge, queue the value y
    // must show one edge after the coming one, then check y after the edge.
    task automatic cyc(input logic r, input logic [11:0] ta, input logic [11:0] tb_,
                       input logic [11:0] tc, input logic te, input bit glitch,
                       input bit has_exp, input logic [39:0] texp, input string nm);
        logic [39:0] got;
        logic [39:0] exp;
        rst_n = r;
        a     = ta;
        b     = tb_;
        c     = tc;
        if (glitch) begin
            e = ~te; #2;
            e = te;  #2;
            e = ~te; #2;
            e = te;
        end else begin
            e = te;
        end
        if (!r) begin
            // Reset clears y at this edge and the next, dropping work in flight.
            if (sbq.size() > 0) sbq[sbq.size()-1] = 40'd0;
            else sbq.push_back(40'd0);
            m_sum = 64'd0;
            sbq.push_back(40'd0);
        end else begin
            if (te) m_sum = (m_sum + prod3(ta, tb_, tc)) & 64'h00FF_FFFF_FFFF;
            sbq.push_back(m_sum[39:0]);
        end
        @(posedge clk);
        #1;
        got = y;
        if (sbq.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: scoreboard empty, y=0x%010h", nm, got);
        end else begin
            exp = sbq.pop_front();
            check(nm, got, exp);
        end
        if (has_exp) check({nm, "_tbl"}, got, texp);
    endtask

    vec_t vt[26];

    initial begin
        logic [39:0] wrap_exp;
        logic [63:0] wrap_full;
        pass_cnt  = 0;
        total_cnt = 0;
        m_sum     = 64'd0;
        rst_n = 1'b0; a = 12'd0; b = 12'd0; c = 12'd0; e = 1'b0;

        //          rst  a     b     c     e     gl  exp
        vt[0]  = '{1'b0, c_oa, c_ob, c_oc, 1'b1, 0, 40'd0};
        vt[1]  = '{1'b0, c_oa, c_ob, c_oc, 1'b1, 0, 40'd0};
        vt[2]  = '{1'b0, c_oa, c_ob, c_oc, 1'b1, 0, 40'd0};
        vt[3]  = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 40'd0};      // first edge after release
        vt[4]  = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 0, c_p};        // single accumulate lands
        vt[5]  = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 0, c_p};        // holds
        vt[6]  = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, c_p};
        vt[7]  = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 2 * c_p};
        vt[8]  = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 3 * c_p};
        vt[9]  = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 4 * c_p};
        vt[10] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 5 * c_p};
        vt[11] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 0, 6 * c_p};    // five repeats added
        vt[12] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 0, 6 * c_p};
        vt[13] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 1, 6 * c_p};    // glitchy enable
        vt[14] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 1, 7 * c_p};
        vt[15] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 1, 7 * c_p};
        vt[16] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 1, 8 * c_p};
        vt[17] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 1, 9 * c_p};
        vt[18] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 1, 9 * c_p};
        vt[19] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 9 * c_p};    // three accumulates
        vt[20] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 10 * c_p};
        vt[21] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 11 * c_p};
        vt[22] = '{1'b0, c_oa, c_ob, c_oc, 1'b1, 0, 40'd0};      // reset mid-run
        vt[23] = '{1'b1, c_oa, c_ob, c_oc, 1'b1, 0, 40'd0};
        vt[24] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 0, c_p};        // restart from 0
        vt[25] = '{1'b1, c_oa, c_ob, c_oc, 1'b0, 0, c_p};

        @(posedge clk);
        #1;
        for (int i = 0; i < 26; i++) begin
            cyc(vt[i].rst_n, vt[i].a, vt[i].b, vt[i].c, vt[i].e, vt[i].glitch,
                1'b1, vt[i].exp_y, $sformatf("vec%0d", i));
        end

        // Wrap-around: 17 maximal products from a cleared sum.
        cyc(1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 0, 1'b1, 40'd0, "wrap_rst");
        for (int i = 0; i < 17; i++)
            cyc(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 0, 1'b0, 40'd0, $sformatf("wrap%0d", i));
        wrap_full = 64'd17 * 64'd68669157375;
        wrap_exp  = wrap_full[39:0];
        cyc(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 0, 1'b0, 40'd0, "wrap_tail");
        cyc(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 0, 1'b1, wrap_exp, "wrap_final");
        cyc(1'b1, 12'h123, 12'h456, 12'h789, 1'b0, 0, 1'b1, wrap_exp, "wrap_hold");

        // Random run with occasional resets.
        for (int i = 0; i < 40; i++) begin
            cyc(($urandom_range(0, 15) != 0), 12'($urandom), 12'($urandom), 12'($urandom),
                1'($urandom), bit'($urandom), 1'b0, 40'd0, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
